// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the I/D request arbiter: master IDs and FSM states.
package sram_req_arbiter_pkg;

  // Master identifier stored in the response-routing FIFO.
  typedef enum logic [0:0] {
    ArbIdInst = 1'b0,
    ArbIdData = 1'b1
  } arb_id_e;

  // Arbiter FSM states.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_id_fifo.sv
// Master-ID FIFO: remembers which master owns each accepted-but-unanswered
// transaction so in-order responses can be routed back.
module arb_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  // No bypass: a pop in the same cycle does not make room for a push.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Storage, pointers (wrap naturally, DEPTH is a power of 2) and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like req/addr_ok/data_ok slave port between the core's
// instruction and data masters. Data has priority; instruction is forced
// through after STARVE_LIMIT consecutive data grants while it waits.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned OUTST_DEPTH  = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  // Instruction master
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  // Data master
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  // Slave (bridge) side
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  arb_state_e         state_q;
  arb_id_e            grant_q;
  arb_id_e            arb_grant;
  arb_id_e            grant;
  logic [StarveW-1:0] starve_q;
  logic               grant_req;
  logic               accept;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_head;
  logic               pop;

  // Idle-time arbitration: data first unless instruction has waited too long.
  always_comb begin
    arb_grant = ArbIdData;
    if (!d_req || (i_req && (starve_q == StarveMax))) begin
      arb_grant = ArbIdInst;
    end
  end

  // Grant is locked while BUSY so the slave sees a stable request.
  assign grant     = (state_q == StBusy) ? grant_q : arb_grant;
  assign grant_req = (grant == ArbIdInst) ? i_req : d_req;
  // Outputs are forced low while reset is asserted, even if masters still request.
  assign s_req     = resetn & grant_req & ~fifo_full;
  assign accept    = s_req & s_addr_ok;
  assign i_addr_ok = accept & (grant == ArbIdInst);
  assign d_addr_ok = accept & (grant == ArbIdData);

  // Slave payload mux from the granted master; zero when no request is presented.
  always_comb begin
    s_wr    = 1'b0;
    s_size  = 2'd0;
    s_wstrb = 4'd0;
    s_addr  = 32'd0;
    s_wdata = 32'd0;
    if (s_req) begin
      if (grant == ArbIdInst) begin
        s_wr    = i_wr;
        s_size  = i_size;
        s_wstrb = i_wstrb;
        s_addr  = i_addr;
        s_wdata = i_wdata;
      end else begin
        s_wr    = d_wr;
        s_size  = d_size;
        s_wstrb = d_wstrb;
        s_addr  = d_addr;
        s_wdata = d_wdata;
      end
    end
  end

  // FSM: leave IDLE when a request is presented but not accepted at once;
  // return to IDLE on acceptance or when the grantee withdraws.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      grant_q <= ArbIdInst;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_req && !s_addr_ok) begin
            state_q <= StBusy;
            grant_q <= arb_grant;
          end
        end
        StBusy: begin
          if (!s_req || s_addr_ok) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Starvation counter: counts data accepts that overtook a waiting instruction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else if (!i_req || (accept && grant == ArbIdInst)) begin
      starve_q <= '0;
    end else if (accept && grant == ArbIdData && starve_q != StarveMax) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  arb_id_fifo #(
    .DEPTH(OUTST_DEPTH)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .push_id(grant),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  // Responses come back in order; the FIFO head says whose they are.
  assign pop       = s_data_ok & ~fifo_empty;
  assign i_data_ok = pop & (fifo_head == ArbIdInst);
  assign d_data_ok = pop & (fifo_head == ArbIdData);
  assign i_rdata   = i_data_ok ? s_rdata : 32'd0;
  assign d_rdata   = d_data_ok ? s_rdata : 32'd0;

`ifndef SYNTHESIS
  // A response with nothing outstanding is a bridge protocol error; it is dropped.
  always_ff @(posedge clk) begin
    if (resetn && s_data_ok && fifo_empty) begin
      $error("sram_req_arbiter: s_data_ok with no outstanding transaction");
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed, table-driven bench for sram_req_arbiter.
module tb_sram_req_arbiter;

  localparam logic [31:0] IAddr  = 32'h1C00_0000;
  localparam logic [31:0] DAddr  = 32'h8000_1000;
  localparam logic [31:0] IWdata = 32'h1111_2222;
  localparam logic [31:0] DWdata = 32'h3333_4444;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0;
  logic        i_wr = 1'b0, d_wr = 1'b1;
  logic [1:0]  i_size = 2'd2, d_size = 2'd0;
  logic [3:0]  i_wstrb = 4'hf, d_wstrb = 4'h1;
  logic [31:0] i_addr = IAddr, d_addr = DAddr;
  logic [31:0] i_wdata = IWdata, d_wdata = DWdata;
  logic        i_addr_ok, d_addr_ok, i_data_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok = 1'b0, s_data_ok = 1'b0;
  logic [31:0] s_rdata = 32'd0;

  int total = 0;
  int bad = 0;

  sram_req_arbiter #(
    .OUTST_DEPTH (4),
    .STARVE_LIMIT(3)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .i_req    (i_req),
    .i_wr     (i_wr),
    .i_size   (i_size),
    .i_wstrb  (i_wstrb),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_size   (d_size),
    .d_wstrb  (d_wstrb),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok),
    .d_rdata  (d_rdata),
    .s_req    (s_req),
    .s_wr     (s_wr),
    .s_size   (s_size),
    .s_wstrb  (s_wstrb),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok),
    .s_rdata  (s_rdata)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected before the next posedge.
  // sel: 0 = no slave request, 1 = I presented, 2 = D presented.
  typedef struct {
    logic        ir, dr, aok, dok;
    logic [31:0] rdata;
    logic        sreq;
    logic [1:0]  sel;
    logic        iaok, daok, idok, ddok;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ir, input logic dr, input logic aok, input logic dok,
                              input logic [31:0] rdata, input logic sreq, input logic [1:0] sel,
                              input logic iaok, input logic daok, input logic idok,
                              input logic ddok);
    vec_t v;
    v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.sreq = sreq; v.sel = sel; v.iaok = iaok; v.daok = daok; v.idok = idok; v.ddok = ddok;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok,
                       input logic [31:0] rdata);
    @(negedge clk);
    i_req = ir; d_req = dr; s_addr_ok = aok; s_data_ok = dok; s_rdata = rdata;
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " s_req"}, 32'(s_req), 32'd0);
    chk({tag, " s_addr"}, s_addr, 32'd0);
    chk({tag, " i_addr_ok"}, 32'(i_addr_ok), 32'd0);
    chk({tag, " d_addr_ok"}, 32'(d_addr_ok), 32'd0);
    chk({tag, " i_data_ok"}, 32'(i_data_ok), 32'd0);
    chk({tag, " d_data_ok"}, 32'(d_data_ok), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_addr;
    string       t;

    // 1: lone I read, accepted one cycle late, then answered.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    // 2: simultaneous I and D: D first, then I; responses D then I.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hBBBB_0002, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    // 3: both held, slave accepts every cycle: D, D, D, then I forced through.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    // 4: FIFO full blocks, also in the cycle of a response; unblocks the cycle after.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'hC000_0001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    // Grant held in BUSY while a response drains.
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'hC000_0002, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1));
    // 5: push and pop in the same cycle at count 2.
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'hC000_0003, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'hC000_0004, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hC000_0005, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hC000_0006, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    // Grantee drops its request in BUSY: back to IDLE with nothing pushed.
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hC000_0007, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Reset state.
    #2;
    chk_quiet("reset");
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].ir, vecs[k].dr, vecs[k].aok, vecs[k].dok, vecs[k].rdata);
      t = $sformatf("v%0d", k);
      exp_addr = (vecs[k].sel == 2'd1) ? IAddr : (vecs[k].sel == 2'd2) ? DAddr : 32'd0;
      chk({t, " s_req"}, 32'(s_req), 32'(vecs[k].sreq));
      chk({t, " s_addr"}, s_addr, exp_addr);
      chk({t, " s_wr"}, 32'(s_wr), 32'(vecs[k].sel == 2'd2));
      chk({t, " i_addr_ok"}, 32'(i_addr_ok), 32'(vecs[k].iaok));
      chk({t, " d_addr_ok"}, 32'(d_addr_ok), 32'(vecs[k].daok));
      chk({t, " i_data_ok"}, 32'(i_data_ok), 32'(vecs[k].idok));
      chk({t, " d_data_ok"}, 32'(d_data_ok), 32'(vecs[k].ddok));
      chk({t, " i_rdata"}, i_rdata, vecs[k].idok ? vecs[k].rdata : 32'd0);
      chk({t, " d_rdata"}, d_rdata, vecs[k].ddok ? vecs[k].rdata : 32'd0);
    end

    // 6: reset mid-BUSY with two outstanding.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("r6 pre accept0", 32'(i_addr_ok), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("r6 pre accept1", 32'(i_addr_ok), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("r6 busy s_req", 32'(s_req), 32'd1);
    #2;
    resetn    = 1'b0;
    s_addr_ok = 1'b1;
    s_data_ok = 1'b1;
    s_rdata   = 32'hDEAD_BEEF;
    #1;
    chk_quiet("r6 in reset");
    chk("r6 i_rdata", i_rdata, 32'd0);
    chk("r6 d_rdata", d_rdata, 32'd0);
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'd0;
    resetn = 1'b1;
    // An empty FIFO after release takes exactly four accepts before blocking.
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      chk($sformatf("r6 refill%0d i_addr_ok", n), 32'(i_addr_ok), 32'd1);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("r6 full s_req", 32'(s_req), 32'd0);
    chk("r6 full i_addr_ok", 32'(i_addr_ok), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
